// File: rtl/load_store_unit.sv
// RV32I load/store stage: aligns store data onto byte lanes, extracts and extends load data,
// and runs one req/ack memory access per request with an acknowledge timeout.
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] loadData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memWstrb,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    localparam logic [15:0] TimeoutLast = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [15:0] r_count;

    logic        w_half;
    logic        w_word;
    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_hword;
    logic [31:0] w_load_ext;

    assign w_half = (funct3[1:0] == 2'b01);
    assign w_word = (funct3[1:0] == 2'b10);
    // Stores only accept 000/001/010; loads additionally accept the unsigned 100/101 forms.
    assign w_illegal = isStore ? (funct3[2] || funct3[1:0] == 2'b11)
                               : (funct3[1:0] == 2'b11 || funct3[2:1] == 2'b11);
    assign w_misaligned = (w_half && addr[0]) || (w_word && addr[1:0] != 2'b00);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (isStore) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << addr[1:0];
                    w_wdata = {4{storeData[7:0]}};
                end
                2'b01: begin
                    w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{storeData[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = storeData;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = memRdata[7:0];
        case (r_off)
            2'd0:    w_byte = memRdata[7:0];
            2'd1:    w_byte = memRdata[15:8];
            2'd2:    w_byte = memRdata[23:16];
            default: w_byte = memRdata[31:24];
        endcase
        w_hword = r_off[1] ? memRdata[31:16] : memRdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_hword[15]}}, w_hword};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b101:  w_load_ext = {16'h0, w_hword};
            default: w_load_ext = memRdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= StIdle;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_count    <= 16'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            loadData   <= 32'h0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= 32'h0;
            memWstrb   <= 4'b0000;
            memWdata   <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_is_store <= isStore;
                        r_funct3   <= funct3;
                        r_off      <= addr[1:0];
                        busy       <= 1'b1;
                        if (w_illegal || w_misaligned) begin
                            r_state  <= StDone;
                            done     <= 1'b1;
                            error    <= 1'b1;
                            loadData <= 32'h0;
                        end else begin
                            r_state  <= StAccess;
                            r_count  <= 16'h0;
                            memReq   <= 1'b1;
                            memWe    <= isStore;
                            memAddr  <= {addr[31:2], 2'b00};
                            memWstrb <= w_wstrb;
                            memWdata <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    // An acknowledge in the final allowed cycle still wins over the timeout.
                    if (memAck || r_count == TimeoutLast) begin
                        r_state  <= StDone;
                        done     <= 1'b1;
                        error    <= !memAck;
                        loadData <= (memAck && !r_is_store) ? w_load_ext : 32'h0;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        memWstrb <= 4'b0000;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized checks of load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] storeData = 32'h0;
    logic [31:0] memRdata = 32'h0;
    logic        memAck = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] loadData;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memWstrb;
    logic [31:0] memWdata;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] mem [16];

    load_store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .isStore   (isStore),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .loadData  (loadData),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWstrb  (memWstrb),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .memAck    (memAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input logic st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] w,
                                             input int unsigned off);
        int unsigned sz = acc_size(f3);
        int unsigned v = w >> (8 * off);
        if (sz < 4) begin
            v = v % (32'd1 << (8 * sz));
            if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input int unsigned off);
        int unsigned m = ((32'd1 << acc_size(f3)) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r = 32'h0;
        int unsigned sz = acc_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
        return r;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".error"}, 32'(error), 32'd0);
        chk({tag, ".loadData"}, loadData, 32'h0);
        chk({tag, ".memReq"}, 32'(memReq), 32'd0);
        chk({tag, ".memWe"}, 32'(memWe), 32'd0);
        chk({tag, ".memAddr"}, memAddr, 32'h0);
        chk({tag, ".memWstrb"}, 32'(memWstrb), 32'd0);
        chk({tag, ".memWdata"}, memWdata, 32'h0);
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int waits, input string tag);
        int unsigned off = 32'(a[1:0]);
        int idx = int'(a[5:2]);
        bit legal = is_legal(st, f3) && (a % acc_size(f3) == 0);
        bit exp_to = (waits >= int'(TO));
        int n_req = 0;
        logic [31:0] exp_ld;
        @(negedge clk);
        start = 1'b1;
        isStore = st;
        funct3 = f3;
        addr = a;
        storeData = sd;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (!legal) begin
            exp_ld = 32'h0;
            chk({tag, ".err_done"}, 32'(done), 32'd1);
            chk({tag, ".err_error"}, 32'(error), 32'd1);
            chk({tag, ".err_memReq"}, 32'(memReq), 32'd0);
            chk({tag, ".err_busy"}, 32'(busy), 32'd1);
            chk({tag, ".err_loadData"}, loadData, exp_ld);
        end else begin
            chk({tag, ".memWe"}, 32'(memWe), 32'(st));
            chk({tag, ".memWstrb"}, 32'(memWstrb), st ? 32'(exp_strb(f3, off)) : 32'd0);
            if (st) chk({tag, ".memWdata"}, memWdata, exp_wdata(f3, sd));
            exp_ld = (st || exp_to) ? 32'h0 : ext_load(f3, mem[idx], off);
            for (int c = 0; c < int'(TO) + 4; c++) begin
                if (memReq !== 1'b1) break;
                n_req++;
                chk({tag, ".memAddr"}, memAddr, a & 32'hFFFF_FFFC);
                if (c == waits) begin
                    memAck = 1'b1;
                    memRdata = st ? $urandom : mem[idx];
                end
                @(posedge clk);
                @(negedge clk);
                memAck = 1'b0;
                start = 1'($urandom % 2);
            end
            chk({tag, ".req_cycles"}, 32'(n_req), exp_to ? TO : 32'(waits + 1));
            chk({tag, ".done"}, 32'(done), 32'd1);
            chk({tag, ".error"}, 32'(error), 32'(exp_to));
            chk({tag, ".loadData"}, loadData, exp_ld);
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            if (st && !exp_to) begin
                for (int i = 0; i < 4; i++)
                    if (exp_strb(f3, off)[i]) mem[idx][8*i +: 8] = exp_wdata(f3, sd)[8*i +: 8];
            end
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".post_busy"}, 32'(busy), 32'd0);
        chk({tag, ".post_done"}, 32'(done), 32'd0);
        chk({tag, ".post_memReq"}, 32'(memReq), 32'd0);
        chk({tag, ".hold_loadData"}, loadData, exp_ld);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rstN = 1'b1;

        mem[0] = 32'h80FF1234;
        run_req(1'b0, 3'b000, 32'h0000_1003, 32'h0, 3, "lb");
        chk("lb.value", loadData, 32'hFFFFFF80);
        mem[0] = 32'hBEEF0000;
        run_req(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, "lhu");
        chk("lhu.value", loadData, 32'h0000BEEF);
        run_req(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, "lh");
        chk("lh.value", loadData, 32'hFFFFBEEF);
        run_req(1'b1, 3'b001, 32'h0000_3002, 32'h1234ABCD, 2, "sh");
        chk("sh.mem", mem[0], 32'hABCD0000);
        run_req(1'b0, 3'b010, 32'h0000_4001, 32'h0, 0, "lw_mis");
        run_req(1'b1, 3'b100, 32'h0000_4000, 32'h0, 0, "st_ill");
        run_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, int'(TO) + 2, "timeout");

        for (int n = 0; n < 80; n++) begin
            logic st = 1'($urandom % 2);
            logic [2:0] f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
            if (!st && $urandom % 3 == 0) f3 = 3'd4 + 3'($urandom % 2);
            run_req(st, f3, $urandom, $urandom, int'($urandom % 6), "rand");
        end

        @(negedge clk);
        start = 1'b1;
        isStore = 1'b0;
        funct3 = 3'b010;
        addr = 32'h0000_0010;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rst.pre_memReq", 32'(memReq), 32'd1);
        #2 rstN = 1'b0;
        #1 check_idle_zero("rst_async");
        @(negedge clk);
        rstN = 1'b1;
        memAck = 1'b1;
        memRdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        memAck = 1'b0;
        chk("late_ack.done", 32'(done), 32'd0);
        chk("late_ack.busy", 32'(busy), 32'd0);
        chk("late_ack.memReq", 32'(memReq), 32'd0);
        run_req(1'b1, 3'b010, 32'h0000_0014, 32'hCAFEF00D, 1, "sw_after_rst");
        chk("sw.mem", mem[5], 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that consumes the ALU's 32-bit result as an effective address and performs one RV32I load or store per request against a word-wide data memory with a req/ack handshake. It sits directly downstream of the ALU. It aligns and byte-enables store data, extracts and sign- or zero-extends load data, and holds the pipeline through `busy` until the access completes. Misaligned or illegal requests, and memory timeouts, complete without side effects and assert `error`.

## Interface
- `ACK_TIMEOUT`, default 255: cycles `memReq` may stay high without `memAck` before the access is aborted. Range 1..65535.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe; sampled only in IDLE.
- `isStore` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- `addr` input 32: effective address (ALU result).
- `storeData` input 32: rs2 value; the low byte or halfword is used for SB/SH.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: valid with `done`; set for misaligned, illegal or timed-out accesses.
- `loadData` output 32: extended load result, valid with `done`; 0 for stores and errors.
- `memReq` output 1: memory request, held until acknowledged.
- `memWe` output 1: write enable, valid with `memReq`.
- `memAddr` output 32: word address, which is `{addr[31:2], 2'b00}`.
- `memWstrb` output 4: byte enables; 0000 for loads.
- `memWdata` output 32: lane-aligned store data.
- `memRdata` input 32: read word, valid in the cycle `memAck` is high.
- `memAck` input 1: one-cycle acknowledge.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - On `start`, latch `isStore`, `funct3`, `addr[1:0]` and the aligned store word.
  - Legality rules:
    - Misaligned means `addr[0]` set for a halfword access, or `addr[1:0]` nonzero for a word access.
    - For stores, `funct3` must be 000, 001 or 010. For loads, it must be one of the five listed load codes.
  - Legal request: go to ACCESS.
  - Misaligned or illegal request: go to DONE with error=1. No `memReq` is issued.
- **ACCESS:**
  - `memReq`=1, and all `mem*` outputs are held stable.
  - The timeout counter starts at 0 and increments every cycle `memAck`=0.
  - On `memAck`: capture and extend the load data, then go to DONE with error=0.
  - If the counter reaches ACK_TIMEOUT-1 without `memAck`: go to DONE with error=1 and `loadData`=0.
- **DONE:**
  - `done`=1 for exactly this one cycle, then return to IDLE.
  - `start` is ignored in DONE and in ACCESS; there is no queuing.
- **Store lanes:**
  - SB: the byte is replicated to all lanes; strobe = `1 << addr[1:0]`.
  - SH: the halfword is replicated to both halves; strobe = 0011 or 1100.
  - SW: strobe = 1111.
- **Load extraction:**
  - The byte or halfword is selected by the latched `addr[1:0]`.
  - LB/LH sign-extend from bit 7 or bit 15. LBU/LHU zero-extend. LW passes the word through.
- **Reset (`rstN`=0):** the state returns to IDLE immediately, even mid-access. All outputs go to 0 (`busy`, `done`, `error`, `loadData`, `memReq`, `memWe`, `memAddr`, `memWstrb`, `memWdata`). The counter clears. An abandoned memory transaction is the memory's responsibility.

## Timing
- Start is sampled at edge 0:
  - `memReq` rises after edge 0.
  - An ack sampled at edge k gives a `done` pulse in cycle k+1, so the minimum latency is start-to-done in 2 cycles.
- Error path: `done` with error=1 in the cycle after the start edge, so latency is 1 cycle.
- `busy` rises with `memReq` (or with `done` on the error path). It falls after the DONE cycle.
- `memAck` outside ACCESS is ignored.
- `loadData` and `error` hold their values until the next `done`.

## Test plan
- LB at `addr`=0x1003, `memRdata`=0x80FF1234, ack after 3 wait cycles:
  - `memAddr`=0x1000, strobe 0000.
  - `done`, `loadData`=0xFFFFFF80, error=0.
- LHU at `addr`=0x2002, `memRdata`=0xBEEF0000: `loadData`=0x0000BEEF. LH at the same address gives 0xFFFFBEEF.
- SH at `addr`=0x3002, `storeData`=0x1234ABCD:
  - `memWe`=1, `memWstrb`=1100, `memWdata`=0xABCDABCD.
  - `done`, error=0.
- Error paths with no `memReq` ever:
  - LW at `addr`=0x4001 gives `done`+error 1 cycle after start.
  - A store with `funct3`=100 gives the same response.
- Timeout: ACK_TIMEOUT=4, `memAck` held low:
  - `memReq` high for exactly 4 cycles.
  - Then `done`, error=1, `loadData`=0.
- `rstN` pulsed low mid-ACCESS:
  - All outputs go to 0 asynchronously.
  - A late `memAck` is ignored, and a following SW completes normally.
